reset_requester: RTL and testbench
==================================

RESET_REQUESTER -- requirements
Module: reset_requester

Interface
REQ-001 Parameter N_STAGE, default 4: synchronizer depth for rst_ack; legal range >= 2.
REQ-002 Parameter MIN_HOLD, default 16: minimum clk cycles rst_req stays high per sequence; legal range >= 1.
REQ-003 Parameter TIMEOUT, default 1024: maximum clk cycles spent waiting in ASSERT or RELEASE; legal only if TIMEOUT > MIN_HOLD.
REQ-004 clk  input  1  clock for all state in this block.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request a remote-domain reset sequence; sampled only in IDLE.
REQ-007 rst_ack  input  1  asynchronous acknowledge from the remote domain, i.e. the remote synchronized reset output.
REQ-008 rst_req  output  1  registered reset request to the remote domain, feeding the remote reset synchronizer input.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a sequence completes successfully.
REQ-011 timeout_err  output  1  sticky error flag; set on timeout.

Function
REQ-012 rst_ack SHALL pass through an N_STAGE flop synchronizer, reset value 0, before any use; the synchronized result is ack_s.
REQ-013 FSM states SHALL be IDLE, ASSERT, RELEASE and DONE.
REQ-014 IDLE: rst_req=0; start=1 -> ASSERT next cycle, clear timeout_err, clear both counters.
REQ-015 ASSERT: rst_req=1; hold_cnt increments each cycle, saturating at MIN_HOLD.
REQ-016 ASSERT exit: when hold_cnt >= MIN_HOLD-1 and ack_s=1 -> RELEASE, which guarantees rst_req high for at least MIN_HOLD cycles.
REQ-017 RELEASE: rst_req=0; wait for ack_s=0 -> DONE.
REQ-018 DONE: rst_req=0; done=1 for exactly this cycle; unconditionally -> IDLE.
REQ-019 wait_cnt SHALL clear on entry to ASSERT and to RELEASE and increment each cycle spent in those states; width is $clog2(TIMEOUT+1).
REQ-020 On wait_cnt reaching TIMEOUT-1 without the exit condition: set timeout_err=1, go to IDLE with rst_req=0, and do not pulse done.
REQ-021 If the exit condition and the timeout occur in the same cycle, the exit condition SHALL win and timeout_err SHALL stay 0.
REQ-022 start in ASSERT, RELEASE or DONE SHALL be ignored and not queued.
REQ-023 If ack_s is already 1 on entry to ASSERT, the block SHALL still hold rst_req high for MIN_HOLD cycles.
REQ-024 rst_req SHALL be driven directly from a flop, with no combinational path from rst_ack or start.
REQ-025 timeout_err SHALL stay set until the next accepted start or rst_in.

Reset
REQ-026 While rst_in=1: state=ASSERT, rst_req=1, busy=1, done=0, timeout_err=0, counters=0, synchronizer=0.
REQ-027 After rst_in deasserts, the block SHALL run a full sequence automatically, so the remote domain is reset at power-up without any start.
REQ-028 rst_in asserted mid-sequence SHALL abort immediately to the REQ-026 values, with no done pulse.

Structure
REQ-029 Shared package reset_pkg SHALL hold the FSM state enum typedef (rr_state_t) and the counter-width helper functions.
REQ-030 The ack synchronizer SHALL be a separate sub-module, sync_bit, with parameters N_STAGE and RESET_VAL and its flops marked ASYNC_REG.
REQ-031 Parameter legality (REQ-001 to REQ-003) SHALL be checked at elaboration time.

Verification
REQ-032 Power-up, MIN_HOLD=16, N_STAGE=4, rst_ack follows rst_req with a 3-cycle delay -> rst_req high >= 16 cycles, one done pulse, then busy=0.
REQ-033 start pulse in IDLE, rst_ack tied 1 -> rst_req high exactly 16 cycles; no RELEASE exit and no done while ack_s=1; timeout_err=1 at wait_cnt=1023.
REQ-034 rst_ack stuck 0, TIMEOUT=64 -> timeout_err=1 after 64 ASSERT cycles, rst_req=0, no done; next start clears timeout_err.
REQ-035 start held high continuously -> back-to-back sequences with exactly one IDLE cycle between DONE and the next ASSERT.
REQ-036 rst_in pulsed while in RELEASE -> same cycle rst_req=1, busy=1, done=0; then a full sequence completes.
REQ-037 ack_s exit and timeout in the same cycle (ack rises at wait_cnt=TIMEOUT-1) -> RELEASE entered, timeout_err=0.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types and sizing helpers for the remote reset requester.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } rr_state_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Terminal value for a counter that must see 'cycles' cycles (0-based).
  function automatic int cnt_last(input int cycles);
    return (cycles < 1) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/reset_requester_if.sv
// Request/acknowledge and status signals between the requester and its user.
interface reset_requester_if;
  logic start;
  logic rst_ack;
  logic rst_req;
  logic busy;
  logic done;
  logic timeout_err;

  modport master (
    input  start,
    input  rst_ack,
    output rst_req,
    output busy,
    output done,
    output timeout_err
  );

  modport slave (
    output start,
    output rst_ack,
    input  rst_req,
    input  busy,
    input  done,
    input  timeout_err
  );
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_bit #(
  parameter int N_STAGE   = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (N_STAGE < 2) begin : g_bad_n_stage
    $error("sync_bit: N_STAGE must be >= 2");
  end

  (* ASYNC_REG = "TRUE" *) logic [N_STAGE-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {N_STAGE{RESET_VAL}};
    else     sync_q <= {sync_q[N_STAGE-2:0], d};
  end

  assign q = sync_q[N_STAGE-1];

endmodule

// File: rtl/reset_requester.sv
// Drives a reset request into a remote domain and waits for its synchronized
// reset to follow high then low, with a hold minimum and a sticky timeout.
//   state   | meaning
//   IDLE    | quiet, waiting for start
//   ASSERT  | rst_req high, waiting for hold time and ack_s=1
//   RELEASE | rst_req low, waiting for ack_s=0
//   DONE    | one-cycle completion pulse
module reset_requester
  import reset_pkg::*;
#(
  parameter int N_STAGE  = 4,
  parameter int MIN_HOLD = 16,
  parameter int TIMEOUT  = 1024
) (
  input logic               clk,
  input logic               rst_in,
  reset_requester_if.master bus
);

  if (N_STAGE < 2) begin : g_bad_n_stage
    $error("reset_requester: N_STAGE must be >= 2");
  end
  if (MIN_HOLD < 1) begin : g_bad_min_hold
    $error("reset_requester: MIN_HOLD must be >= 1");
  end
  if (TIMEOUT <= MIN_HOLD) begin : g_bad_timeout
    $error("reset_requester: TIMEOUT must exceed MIN_HOLD");
  end

  localparam int HOLD_W = cnt_width(MIN_HOLD);
  localparam int WAIT_W = cnt_width(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_EXIT = HOLD_W'(cnt_last(MIN_HOLD));
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(cnt_last(TIMEOUT));

  rr_state_t         state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              rst_req_q;
  logic              timeout_err_q, err_nxt;
  logic              ack_s;

  sync_bit #(
    .N_STAGE  (N_STAGE),
    .RESET_VAL(1'b0)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst_in),
    .d  (bus.rst_ack),
    .q  (ack_s)
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    wait_nxt  = wait_cnt;
    err_nxt   = timeout_err_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_ASSERT;
          hold_nxt  = '0;
          wait_nxt  = '0;
          err_nxt   = 1'b0;
        end
      end
      ST_ASSERT: begin
        // Exit is tested before timeout so a tie completes normally.
        if (hold_cnt >= HOLD_EXIT && ack_s) begin
          state_nxt = ST_RELEASE;
          wait_nxt  = '0;
        end else if (wait_cnt >= WAIT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else begin
          if (hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + 1'b1;
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_nxt = ST_DONE;
        end else if (wait_cnt >= WAIT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Reset parks in ASSERT so a full sequence runs after power-up.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_ASSERT;
      hold_cnt      <= '0;
      wait_cnt      <= '0;
      rst_req_q     <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      wait_cnt      <= wait_nxt;
      rst_req_q     <= (state_nxt == ST_ASSERT);
      timeout_err_q <= err_nxt;
    end
  end

  assign bus.rst_req     = rst_req_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = (state == ST_DONE);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reset_requester.sv
// Scoreboard bench: a delayed-echo remote domain, per-sequence predictions
// pushed at start and checked when busy drops.
module tb_reset_requester;

  localparam int N_STAGE  = 4;
  localparam int MIN_HOLD = 16;
  localparam int TIMEOUT  = 64;

  typedef enum int {M_DELAY, M_STUCK0, M_STUCK1} ack_mode_t;

  typedef struct {
    bit want_done;
    int hi;
    int busy_len;
    bit exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  reset_requester_if bus ();

  reset_requester #(
    .N_STAGE (N_STAGE),
    .MIN_HOLD(MIN_HOLD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  exp_t      q[$];
  ack_mode_t mode = M_DELAY;
  int        dly  = 3;
  logic [127:0] hist;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_checks++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d (t=%0t)", name, act, lim, $time);
    end
  endtask

  // Remote domain: its reset output echoes rst_req after dly samples, or is stuck.
  initial begin
    hist = '0;
    bus.rst_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      hist = {hist[126:0], bus.rst_req};
      case (mode)
        M_STUCK0: bus.rst_ack = 1'b0;
        M_STUCK1: bus.rst_ack = 1'b1;
        default:  bus.rst_ack = hist[dly-1];
      endcase
    end
  end

  // Sequence outcome from the rules: ack is seen N_STAGE+dly-1 cycles after
  // rst_req changes; exit needs MIN_HOLD cycles high; TIMEOUT cycles per wait.
  function automatic exp_t predict(input ack_mode_t m, input int d);
    exp_t e;
    int   k_ack;
    e.exact = 1'b1;
    case (m)
      M_STUCK0: begin
        e.want_done = 1'b0; e.hi = TIMEOUT; e.busy_len = TIMEOUT;
      end
      M_STUCK1: begin
        e.want_done = 1'b0; e.hi = MIN_HOLD; e.busy_len = MIN_HOLD + TIMEOUT;
      end
      default: begin
        k_ack = N_STAGE + d - 1;
        if (k_ack > TIMEOUT - 1) begin
          e.want_done = 1'b0; e.hi = TIMEOUT; e.busy_len = TIMEOUT;
        end else begin
          e.want_done = 1'b1;
          e.hi        = (k_ack + 1 > MIN_HOLD) ? k_ack + 1 : MIN_HOLD;
          e.busy_len  = e.hi + (N_STAGE + d) + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: measures each busy interval and checks it against the queue head.
  int   hi_c = 0, busy_c = 0, done_c = 0;
  bit   prev_busy = 1'b1;
  exp_t e_mon;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.busy) begin
        busy_c++;
        if (bus.rst_req) hi_c++;
        if (bus.done) done_c++;
      end
      if (prev_busy && !bus.busy) begin
        if (q.size() == 0) begin
          check("unexpected_sequence", busy_c, 0);
        end else begin
          e_mon = q.pop_front();
          check("done_pulses", done_c, e_mon.want_done ? 1 : 0);
          check("timeout_err_at_end", int'(bus.timeout_err), e_mon.want_done ? 0 : 1);
          if (e_mon.exact) begin
            check("rst_req_high_cycles", hi_c, e_mon.hi);
            check("busy_cycles", busy_c, e_mon.busy_len);
          end else begin
            check_ge("rst_req_high_cycles_min", hi_c, e_mon.hi);
          end
        end
        hi_c = 0; busy_c = 0; done_c = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(input ack_mode_t m, input int d);
    mode = m;
    dly  = d;
    tick(80);
  endtask

  task automatic fire(input exp_t e);
    q.push_back(e);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((q.size() != 0 || bus.busy) && c < budget) begin
      tick(1);
      c++;
    end
    if (c >= budget) begin
      check("drain_within_budget", c, 0);
      q.delete();
    end
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  exp_t e_main;

  initial begin
    int c;
    ack_mode_t m;
    int d;
    int r;

    bus.start = 1'b0;
    #2 rst_in = 1'b1;

    // Power-up: remote echoes with a 3-cycle delay.
    e_main = '{want_done: 1'b1, hi: MIN_HOLD, busy_len: 0, exact: 1'b0};
    q.push_back(e_main);
    tick(3);
    check("reset_rst_req", int'(bus.rst_req), 1);
    check("reset_busy", int'(bus.busy), 1);
    check("reset_done", int'(bus.done), 0);
    check("reset_timeout_err", int'(bus.timeout_err), 0);
    @(negedge clk);
    rst_in = 1'b0;
    drain(400);
    tick(3);
    check("powerup_then_idle", int'(bus.busy), 0);

    // Ack stuck high: hold time only, then RELEASE times out.
    settle(M_STUCK1, 1);
    fire(predict(M_STUCK1, 1));
    drain(400);

    // Ack stuck low: ASSERT times out; flag is sticky until the next start.
    settle(M_STUCK0, 1);
    fire(predict(M_STUCK0, 1));
    drain(400);
    settle(M_DELAY, 5);
    check("timeout_err_sticky", int'(bus.timeout_err), 1);
    fire(predict(M_DELAY, 5));
    check("timeout_err_cleared_by_start", int'(bus.timeout_err), 0);
    drain(400);

    // Ack seen exactly on the last wait cycle, and one cycle too late.
    settle(M_DELAY, TIMEOUT - N_STAGE);
    fire(predict(M_DELAY, TIMEOUT - N_STAGE));
    drain(400);
    settle(M_DELAY, TIMEOUT - N_STAGE + 1);
    fire(predict(M_DELAY, TIMEOUT - N_STAGE + 1));
    drain(400);

    // start held high: back-to-back with a single IDLE cycle between.
    settle(M_DELAY, 2);
    e_main = predict(M_DELAY, 2);
    q.push_back(e_main);
    q.push_back(e_main);
    bus.start = 1'b1;
    c = 0;
    tick(1);
    while (bus.busy && c < 300) begin
      tick(1);
      c++;
    end
    check("b2b_first_ends", int'(bus.busy), 0);
    tick(1);
    check("b2b_one_idle_cycle", int'(bus.busy), 1);
    bus.start = 1'b0;
    drain(400);
    tick(20);
    check("start_not_queued", int'(bus.busy), 0);

    // rst_in pulsed in RELEASE: immediate abort, then a full sequence.
    settle(M_DELAY, 3);
    e_main = '{want_done: 1'b1, hi: MIN_HOLD, busy_len: 0, exact: 1'b0};
    fire(e_main);
    c = 0;
    while (bus.rst_req && c < 300) begin
      tick(1);
      c++;
    end
    check("reached_release", int'(bus.rst_req), 0);
    @(negedge clk);
    rst_in = 1'b1;
    #1;
    check("abort_rst_req", int'(bus.rst_req), 1);
    check("abort_busy", int'(bus.busy), 1);
    check("abort_done", int'(bus.done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    drain(400);

    // Randomized ack behaviour, with ignored start pulses mid-sequence.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      m = (r < 7) ? M_DELAY : ((r < 8) ? M_STUCK0 : M_STUCK1);
      d = $urandom_range(1, 66);
      settle(m, d);
      fire(predict(m, d));
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(0, MIN_HOLD - 3));
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
      end
      drain(400);
    end

    tick(5);
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
